// File: rtl/phy_tx_arbiter.sv
// Frame-level round-robin arbiter sharing the PHY TX FIFO write port between two sources.
// Latency: 1 cycle from accepted source byte to phy_din/phy_wr_en; grant 1 cycle after request in IDLE.
// Backpressure: phy_full drops source ready combinationally; abort terminator waits while phy_full.
module phy_tx_arbiter #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1600
) (
  input  logic        pcie_clk,
  input  logic        sys_rst_n,
  input  logic        s0_req,
  input  logic        s1_req,
  output logic        s0_gnt,
  output logic        s1_gnt,
  input  logic [8:0]  s0_din,
  input  logic [8:0]  s1_din,
  input  logic        s0_wr_en,
  input  logic        s1_wr_en,
  input  logic        s0_last,
  input  logic        s1_last,
  output logic        s0_ready,
  output logic        s1_ready,
  output logic [8:0]  phy_din,
  output logic        phy_wr_en,
  input  logic        phy_full,
  output logic [15:0] frm_cnt0,
  output logic [15:0] frm_cnt1,
  output logic [7:0]  abort_cnt,
  output logic        busy
);

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_XFER  = 2'd1;
  localparam logic [1:0] ARB_ABORT = 2'd2;
  localparam logic [1:0] ARB_GAP   = 2'd3;

  localparam int              GW       = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LOAD = GW'(IFG_CYCLES - 1);
  localparam logic [10:0]     LEN_LAST = 11'(MAX_LEN - 1);

  logic [1:0]    state;
  logic          sel;      // source currently owning the port (1 = s1)
  logic          prio;     // source favoured on the next contended grant
  logic [10:0]   len;
  logic [GW-1:0] gap_cnt;

  logic       in_xfer;
  logic       sel_req;
  logic       sel_wr_en;
  logic       sel_last;
  logic       sel_ready;
  logic [8:0] sel_din;
  logic       accept;
  logic       frame_done;
  logic       abort_wr;
  logic       pick_s1;

  assign in_xfer  = (state == ARB_XFER);
  assign s0_ready = s0_gnt & in_xfer & ~phy_full;
  assign s1_ready = s1_gnt & in_xfer & ~phy_full;
  assign busy     = (state != ARB_IDLE);

  // Mux the granted source and derive the per-cycle transfer events.
  always_comb begin
    sel_req    = sel ? s1_req   : s0_req;
    sel_wr_en  = sel ? s1_wr_en : s0_wr_en;
    sel_last   = sel ? s1_last  : s0_last;
    sel_ready  = sel ? s1_ready : s0_ready;
    sel_din    = sel ? s1_din   : s0_din;
    accept     = in_xfer & sel_wr_en & sel_ready;
    frame_done = accept & sel_last;
    abort_wr   = (state == ARB_ABORT) & ~phy_full;
    pick_s1    = s1_req & (~s0_req | prio);
  end

  // Arbitration FSM: grant, length tracking, abort detection and inter-frame gap.
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ARB_IDLE;
      s0_gnt  <= 1'b0;
      s1_gnt  <= 1'b0;
      sel     <= 1'b0;
      prio    <= 1'b0;
      len     <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          len <= '0;
          if (s0_req | s1_req) begin
            sel    <= pick_s1;
            s0_gnt <= ~pick_s1;
            s1_gnt <= pick_s1;
            state  <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (accept) begin
            len <= len + 11'd1;
          end
          if (frame_done) begin
            s0_gnt  <= 1'b0;
            s1_gnt  <= 1'b0;
            prio    <= ~sel;
            gap_cnt <= GAP_LOAD;
            state   <= ARB_GAP;
          end else if ((accept && (len == LEN_LAST)) || !sel_req) begin
            // Overlength or source walked away mid-frame: terminate it ourselves.
            s0_gnt <= 1'b0;
            s1_gnt <= 1'b0;
            state  <= ARB_ABORT;
          end
        end
        ARB_ABORT: begin
          if (!phy_full) begin
            prio    <= ~sel;
            gap_cnt <= GAP_LOAD;
            state   <= ARB_GAP;
          end
        end
        default: begin
          if (gap_cnt == '0) begin
            state <= ARB_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // PHY write port: forward accepted bytes, or the tx_en=0 terminator on abort.
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phy_din   <= '0;
      phy_wr_en <= 1'b0;
    end else begin
      phy_wr_en <= 1'b0;
      if (accept) begin
        phy_din   <= sel_din;
        phy_wr_en <= 1'b1;
      end else if (abort_wr) begin
        phy_din   <= 9'h000;
        phy_wr_en <= 1'b1;
      end
    end
  end

  // Status counters: completed frames wrap, aborts saturate.
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frm_cnt0  <= '0;
      frm_cnt1  <= '0;
      abort_cnt <= '0;
    end else begin
      if (frame_done && !sel) begin
        frm_cnt0 <= frm_cnt0 + 16'd1;
      end
      if (frame_done && sel) begin
        frm_cnt1 <= frm_cnt1 + 16'd1;
      end
      if (abort_wr && (abort_cnt != 8'hFF)) begin
        abort_cnt <= abort_cnt + 8'd1;
      end
    end
  end

endmodule
